// File: rtl/grf_arb_pkg.sv
// Shared types and widths for the GRF write-port arbiter.
// Provides GPR/data widths, requester ids and the write-request bundle.
package grf_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_GPR    = 32;

    typedef enum logic {
        REQ_PIPE = 1'b0,
        REQ_MDU  = 1'b1
    } req_id_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic [DATA_W-1:0]     pc;
    } wr_req_t;

endpackage

// File: rtl/grf_arb_scoreboard.sv
// Busy bit per GPR for outstanding long-latency (port-1) writes.
// Ports: clk, reset (sync, active-low), set_en/set_addr (issue),
//        clr_en/clr_addr (port-1 transfer), busy (registered bitmap).
module grf_arb_scoreboard
    import grf_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic [NUM_GPR-1:0]    busy
);

    logic [NUM_GPR-1:0] busy_next;

    // Clear applied before set so a same-cycle set on the
    // same register keeps it busy. x0 is never tracked.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/grf_write_arbiter.sv
// Fixed-priority arbiter for the single GRF write port with a starvation
// guard for the multiply/divide path, and registered GRF write outputs.
// Ports: clk, reset (sync, active-low); req0_* pipeline writeback,
//   req1_* mul/div result (valid/ready/addr/data/pc); grf_we/a3/wd/pc
//   registered write; alloc_valid/alloc_addr issue notify; busy bitmap.
// Build option: GRF_ARB_SCOREBOARD_EN instantiates the busy scoreboard;
//   otherwise busy is 0 and alloc_* are ignored.
module grf_write_arbiter
    import grf_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [REG_ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_data,
    input  logic [DATA_W-1:0]     req0_pc,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [REG_ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_data,
    input  logic [DATA_W-1:0]     req1_pc,
    output logic                  grf_we,
    output logic [REG_ADDR_W-1:0] grf_a3,
    output logic [DATA_W-1:0]     grf_wd,
    output logic [DATA_W-1:0]     grf_pc,
    input  logic                  alloc_valid,
    input  logic [REG_ADDR_W-1:0] alloc_addr,
    output logic [NUM_GPR-1:0]    busy
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic       [2:0] starve_cnt;
    logic             force1;
    logic             xfer0;
    logic             xfer1;
    req_id_e          winner;
    wr_req_t          win_req;

    assign force1     = (starve_cnt == LIMIT);
    assign req0_ready = !(force1 && req1_valid);
    assign req1_ready = !req0_valid || force1;

    // Ready terms make these mutually exclusive.
    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;

    always_comb begin
        winner  = xfer1 ? REQ_MDU : REQ_PIPE;
        win_req = (winner == REQ_MDU)
                ? '{addr: req1_addr, data: req1_data, pc: req1_pc}
                : '{addr: req0_addr, data: req0_data, pc: req0_pc};
    end

    // Counts consecutive blocked cycles of a waiting port-1 request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!req1_valid || req1_ready) begin
            starve_cnt <= '0;
        end else if (!force1) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            grf_we <= 1'b0;
            grf_a3 <= '0;
            grf_wd <= '0;
            grf_pc <= '0;
        end else if (xfer0 || xfer1) begin
            grf_we <= (win_req.addr != '0);
            grf_a3 <= win_req.addr;
            grf_wd <= win_req.data;
            grf_pc <= win_req.pc;
        end else begin
            grf_we <= 1'b0;
        end
    end

`ifdef GRF_ARB_SCOREBOARD_EN
    grf_arb_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (alloc_valid),
        .set_addr (alloc_addr),
        .clr_en   (xfer1),
        .clr_addr (req1_addr),
        .busy     (busy)
    );
`else
    logic unused_alloc;
    assign unused_alloc = ^{alloc_valid, alloc_addr};
    assign busy         = '0;
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Self-checking bench for grf_write_arbiter: directed scenarios followed
// by random traffic against a behavioural reference model.
module tb_grf_write_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data, req0_pc;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data, req1_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic [31:0] busy;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_blocked = 0;
    logic        m_we = 0;
    logic [4:0]  m_a3 = 0;
    logic [31:0] m_wd = 0, m_pc = 0;
    bit          m_busy [32];

    grf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data), .req0_pc(req0_pc),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data), .req1_pc(req1_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] v;
        v = '0;
`ifdef GRF_ARB_SCOREBOARD_EN
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
`endif
        return v;
    endfunction

    // One clock cycle: drive, check grants, clock, check registered outputs.
    task automatic step(
        input logic rst_n,
        input logic v0, input logic [4:0] a0,
        input logic [31:0] d0, input logic [31:0] p0,
        input logic v1, input logic [4:0] a1,
        input logic [31:0] d1, input logic [31:0] p1,
        input logic av, input logic [4:0] aa
    );
        bit starving, win0, win1;
        reset = rst_n;
        req0_valid = v0; req0_addr = a0; req0_data = d0; req0_pc = p0;
        req1_valid = v1; req1_addr = a1; req1_data = d1; req1_pc = p1;
        alloc_valid = av; alloc_addr = aa;
        #2;
        starving = (m_blocked >= LIMIT);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, !(starving && v1)});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, (!v0 || starving)});
        // Port 1 wins when starving or when port 0 is idle.
        win1 = v1 && (starving || !v0);
        win0 = v0 && !win1;
        @(posedge clk);
        if (!rst_n) begin
            m_blocked = 0;
            m_we = 0; m_a3 = 0; m_wd = 0; m_pc = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            if (win0) begin
                m_we = (a0 != 0); m_a3 = a0; m_wd = d0; m_pc = p0;
            end else if (win1) begin
                m_we = (a1 != 0); m_a3 = a1; m_wd = d1; m_pc = p1;
            end else begin
                m_we = 0;
            end
            if (v1 && !win1)
                m_blocked = (m_blocked + 1 > LIMIT) ? LIMIT : m_blocked + 1;
            else
                m_blocked = 0;
            if (win1) m_busy[a1] = 0;
            if (av && aa != 0) m_busy[aa] = 1;
        end
        #1;
        chk("grf_we", {31'd0, grf_we}, {31'd0, m_we});
        chk("grf_a3", {27'd0, grf_a3}, {27'd0, m_a3});
        chk("grf_wd", grf_wd, m_wd);
        chk("grf_pc", grf_pc, m_pc);
        chk("busy", busy, model_busy());
    endtask

    task automatic idle(input logic rst_n);
        step(rst_n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
        // Reset state
        idle(0);
        idle(0);
        idle(1);
        // Single port-0 write, then idle shows we drops
        step(1, 1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0, 0, 0);
        chk("single_we", {31'd0, grf_we}, 32'd1);
        chk("single_a3", {27'd0, grf_a3}, 32'd5);
        idle(1);
        chk("single_we_drop", {31'd0, grf_we}, 32'd0);
        // Contention: port 0 first, then port 1
        step(1, 1, 3, 32'h33, 32'h100, 1, 4, 32'h44, 32'h200, 0, 0);
        chk("cont_first", {27'd0, grf_a3}, 32'd3);
        step(1, 0, 0, 0, 0, 1, 4, 32'h44, 32'h200, 0, 0);
        chk("cont_second", {27'd0, grf_a3}, 32'd4);
        idle(1);
        // Starvation: port 1 forced on the 5th cycle
        for (int c = 0; c < 10; c++) begin
            step(1, 1, 5'(c + 1), 32'(c), 32'h4000 + 32'(c),
                 1, 7, 32'hBEEF, 32'h5000, 0, 0);
            if (c == 4) chk("starve_win", {27'd0, grf_a3}, 32'd7);
        end
        idle(1);
        // Address 0 via port 1
        step(1, 0, 0, 0, 0, 1, 0, 32'hFFFF, 32'h6000, 0, 0);
        chk("addr0_we", {31'd0, grf_we}, 32'd0);
        idle(1);
        // Scoreboard: alloc, clear, and simultaneous set/clear
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        step(1, 0, 0, 0, 0, 1, 9, 32'h99, 32'h7000, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        step(1, 0, 0, 0, 0, 1, 9, 32'h98, 32'h7004, 1, 9);
        idle(1);
        // Reset mid-stream drops the in-flight write
        step(1, 1, 12, 32'hC0DE, 32'h8000, 1, 13, 32'h1, 32'h2, 1, 13);
        step(0, 1, 14, 32'hD0D0, 32'h8004, 1, 13, 32'h1, 32'h2, 0, 0);
        chk("rst_mid_we", {31'd0, grf_we}, 32'd0);
        idle(1);
        // Random traffic
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(39) != 0),
                 ($urandom_range(1) == 1), 5'($urandom_range(7)),
                 $urandom, $urandom,
                 ($urandom_range(9) < 6), 5'($urandom_range(7)),
                 $urandom, $urandom,
                 ($urandom_range(9) < 3), 5'($urandom_range(7)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
